ps2_bet_event_queue: RTL
========================

Name: ps2_bet_event_queue

Overview:
- Sequential successor to the combinational keyboard-to-bet mapper.
- Consumes raw PS/2 scan-code bytes from the keyboard receiver and parses make/break/extended/pause sequences.
- Translates each key press into a bet opcode and buffers the opcodes in a parametrised FIFO.
- The bet/game FSM drains the FIFO through a valid/ready handshake, so no key press is lost while the wheel logic is busy.

Parameters:
- OPW, 6: bet opcode width; must be ≥6.
- FIFO_DEPTH, 4: opcode queue depth; power of two, ≥2.
- CNT_W, $clog2(FIFO_DEPTH+1): width of fifo_count (derived; do not override).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- scan_code  in  8  byte from the PS/2 receiver.
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle.
- bet_ready  in  1  consumer accepts the head opcode this cycle.
- bet_opcode  out  OPW  head-of-queue opcode; zero-extended from 6 bits.
- bet_valid  out  1  queue is non-empty.
- fifo_count  out  CNT_W  current occupancy.
- overflow  out  1  sticky: an event was dropped because the queue was full.

Behaviour:
- Reset values: bet_valid=0, bet_opcode=0, fifo_count=0, overflow=0. Parser state=S_IDLE, held key cleared, pointers=0.
- Reset mid-sequence discards any partial prefix and all queued opcodes.
- Parser FSM advances only on cycles where scan_valid=1:
  - S_IDLE: F0→S_BRK; E0→S_EXT; E1→S_PAUSE (skip counter=7); any other byte is a make event → S_IDLE.
  - S_EXT: F0→S_EXT_BRK; any other byte is a make event with the E0 prefix stripped → S_IDLE.
  - S_BRK and S_EXT_BRK: the byte is a release. If it equals the held key, clear the held key. Go to S_IDLE. Never enqueue.
  - S_PAUSE: decrement the counter on each byte; go to S_IDLE when it reaches 0. Never enqueue.
- Make event: the byte is looked up in bet_code_lut. Unmapped codes (NONE=6'h3F) are dropped silently. Mapped codes are pushed in the same cycle.
- Latency: a push in cycle N makes bet_valid=1 and presents the opcode in cycle N+1. There is no bypass when the queue is empty.
- Pop occurs when bet_valid & bet_ready. The head advances the next cycle.
- Push while full without a pop: drop the event, set overflow, leave queue contents unchanged.
- Push and pop in the same cycle while full: both succeed; count stays at FIFO_DEPTH; overflow is not set.
- bet_ready while empty: ignored.
- Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
- overflow clears only on reset.

Optional Feature:
- Macro: TYPEMATIC_FILTER_EN.
- Defined:
  - A held-key register (code + valid) records the last make.
  - A repeated make of the held code with no intervening release is suppressed (typematic auto-repeat).
  - A make of a different code replaces the held key and is enqueued.
- Undefined:
  - No held-key register exists; every mapped make, including auto-repeats, is enqueued.
  - Releases only affect parser state.

Decomposition:
- bet_pkg:
  - Opcode constants: numbers 0..36 as their value; DOUBLE_ZERO=37; RED=6'h26; BLACK=6'h27; EVEN=6'h28; ODD=6'h29; LOW_1_18=6'h2A; HIGH_19_36=6'h2B; DOZ1=6'h2C; DOZ2=6'h2D; DOZ3=6'h2E; COL_TOP=6'h2F; COL_MID=6'h30; COL_BOT=6'h31; SPIN=6'h3E; NONE=6'h3F.
  - Also holds the parser state enum and the PS2_BREAK, PS2_EXT and PS2_PAUSE byte constants.
- Sub-module bet_code_lut (combinational), byte→opcode:
  - Row 3: 0E,16,1E,26,25,2E,36,3D,3E,46,45,4E,55 → 0,3,6,…,36; 66→COL_TOP.
  - Row 2: 0D→37; 15,1D,24,2D,2C,35,3C,43,44,4D,54,5B → 2,5,…,35; 5D→COL_MID.
  - Row 1: 58,1C,1B,23,2B,34,33,3B,42,4B,4C,52 → 1,4,…,34; 5A→COL_BOT.
  - Ranges: 12→LOW; 22→DOZ1; 32→DOZ2; 41→DOZ3; 59→HIGH.
  - Colours/parity/spin: 1F→RED; 11→ODD; 29→SPIN; 2F→EVEN; 14→BLACK.
  - All other bytes → NONE.

Test Plan:
- Byte 16 with bet_ready=0 → next cycle bet_valid=1, bet_opcode=3, fifo_count=1.
- Sequence 16, F0, 16 → exactly one opcode (3) enqueued; parser returns to S_IDLE.
- Sequence E0 14 then E0 F0 14 → one BLACK (6'h27) enqueued. Sequence E1 14 77 E1 F0 14 F0 77 → nothing enqueued.
- Five mapped makes with FIFO_DEPTH=4 and bet_ready=0 → fifo_count=4, overflow=1, drained order equals the first four. Push+pop while full → count stays 4, overflow unchanged.
- With TYPEMATIC_FILTER_EN: 1D 1D 1D, then F0 1D, then 1D → two opcodes of 5. Without the macro → four opcodes of 5.
- Unmapped byte 76 → no push. Reset asserted after E0 → next 1F enqueues RED; queue empty right after reset.

Source files
------------

// File: rtl/bet_pkg.sv
// Shared constants for the PS/2 bet event queue: opcode values, PS/2 prefix bytes
// and the scan-code parser state encoding.
package bet_pkg;

  localparam logic [5:0] OP_DOUBLE_ZERO = 6'd37;
  localparam logic [5:0] OP_RED         = 6'h26;
  localparam logic [5:0] OP_BLACK       = 6'h27;
  localparam logic [5:0] OP_EVEN        = 6'h28;
  localparam logic [5:0] OP_ODD         = 6'h29;
  localparam logic [5:0] OP_LOW_1_18    = 6'h2A;
  localparam logic [5:0] OP_HIGH_19_36  = 6'h2B;
  localparam logic [5:0] OP_DOZ1        = 6'h2C;
  localparam logic [5:0] OP_DOZ2        = 6'h2D;
  localparam logic [5:0] OP_DOZ3        = 6'h2E;
  localparam logic [5:0] OP_COL_TOP     = 6'h2F;
  localparam logic [5:0] OP_COL_MID     = 6'h30;
  localparam logic [5:0] OP_COL_BOT     = 6'h31;
  localparam logic [5:0] OP_SPIN        = 6'h3E;
  localparam logic [5:0] OP_NONE        = 6'h3F;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Pause sends E1 followed by seven further bytes that carry no key meaning.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK,
    S_PAUSE
  } ps2_state_e;

endpackage

// File: rtl/bet_code_lut.sv
// Combinational PS/2 set-2 scan code to bet opcode table; unmapped bytes give OP_NONE.
module bet_code_lut
  import bet_pkg::*;
(
  input  logic [7:0] code_i,
  output logic [5:0] opcode_o
);

  always_comb begin
    opcode_o = OP_NONE;
    case (code_i)
      // top row of the table: 0,3,...,36
      8'h0E: opcode_o = 6'd0;
      8'h16: opcode_o = 6'd3;
      8'h1E: opcode_o = 6'd6;
      8'h26: opcode_o = 6'd9;
      8'h25: opcode_o = 6'd12;
      8'h2E: opcode_o = 6'd15;
      8'h36: opcode_o = 6'd18;
      8'h3D: opcode_o = 6'd21;
      8'h3E: opcode_o = 6'd24;
      8'h46: opcode_o = 6'd27;
      8'h45: opcode_o = 6'd30;
      8'h4E: opcode_o = 6'd33;
      8'h55: opcode_o = 6'd36;
      8'h66: opcode_o = OP_COL_TOP;
      // middle row: 00 then 2,5,...,35
      8'h0D: opcode_o = OP_DOUBLE_ZERO;
      8'h15: opcode_o = 6'd2;
      8'h1D: opcode_o = 6'd5;
      8'h24: opcode_o = 6'd8;
      8'h2D: opcode_o = 6'd11;
      8'h2C: opcode_o = 6'd14;
      8'h35: opcode_o = 6'd17;
      8'h3C: opcode_o = 6'd20;
      8'h43: opcode_o = 6'd23;
      8'h44: opcode_o = 6'd26;
      8'h4D: opcode_o = 6'd29;
      8'h54: opcode_o = 6'd32;
      8'h5B: opcode_o = 6'd35;
      8'h5D: opcode_o = OP_COL_MID;
      // bottom row: 1,4,...,34
      8'h58: opcode_o = 6'd1;
      8'h1C: opcode_o = 6'd4;
      8'h1B: opcode_o = 6'd7;
      8'h23: opcode_o = 6'd10;
      8'h2B: opcode_o = 6'd13;
      8'h34: opcode_o = 6'd16;
      8'h33: opcode_o = 6'd19;
      8'h3B: opcode_o = 6'd22;
      8'h42: opcode_o = 6'd25;
      8'h4B: opcode_o = 6'd28;
      8'h4C: opcode_o = 6'd31;
      8'h52: opcode_o = 6'd34;
      8'h5A: opcode_o = OP_COL_BOT;
      8'h12: opcode_o = OP_LOW_1_18;
      8'h22: opcode_o = OP_DOZ1;
      8'h32: opcode_o = OP_DOZ2;
      8'h41: opcode_o = OP_DOZ3;
      8'h59: opcode_o = OP_HIGH_19_36;
      8'h1F: opcode_o = OP_RED;
      8'h11: opcode_o = OP_ODD;
      8'h29: opcode_o = OP_SPIN;
      8'h2F: opcode_o = OP_EVEN;
      8'h14: opcode_o = OP_BLACK;
      default: opcode_o = OP_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_bet_event_queue.sv
// PS/2 scan-code parser feeding a bet opcode FIFO drained by valid/ready.
// Define TYPEMATIC_FILTER_EN to suppress keyboard auto-repeat of the held key.
module ps2_bet_event_queue
  import bet_pkg::*;
#(
  parameter int OPW        = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       scan_code,
  input  logic             scan_valid,
  input  logic             bet_ready,
  output logic [OPW-1:0]   bet_opcode,
  output logic             bet_valid,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  ps2_state_e       state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             make_evt;
  logic             push_req, push, pop, full;
  logic [5:0]       lut_op;
  logic [5:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  bet_code_lut u_lut (.code_i(scan_code), .opcode_o(lut_op));

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    make_evt = 1'b0;
    if (scan_valid) begin
      case (state_q)
        S_IDLE: begin
          if (scan_code == PS2_BREAK)      state_d = S_BRK;
          else if (scan_code == PS2_EXT)   state_d = S_EXT;
          else if (scan_code == PS2_PAUSE) begin
            state_d = S_PAUSE;
            skip_d  = PAUSE_SKIP;
          end else                         make_evt = 1'b1;
        end
        S_EXT: begin
          if (scan_code == PS2_BREAK) state_d = S_EXT_BRK;
          else begin
            make_evt = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: state_d = S_IDLE;
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] held_code_q;
  logic       held_vld_q;
  logic       rel_evt, held_hit;

  assign rel_evt  = scan_valid && (state_q == S_BRK || state_q == S_EXT_BRK);
  assign held_hit = held_vld_q && (held_code_q == scan_code);
  assign push_req = make_evt && (lut_op != OP_NONE) && !held_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      held_code_q <= '0;
      held_vld_q  <= 1'b0;
    end else if (push_req) begin
      held_code_q <= scan_code;
      held_vld_q  <= 1'b1;
    end else if (rel_evt && held_hit) begin
      held_vld_q  <= 1'b0;
    end
  end
`else
  assign push_req = make_evt && (lut_op != OP_NONE);
`endif

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop  = bet_valid && bet_ready;
  assign push = push_req && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (push_req && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= lut_op;
  end

  assign bet_valid  = (count_q != '0);
  assign bet_opcode = bet_valid ? OPW'(mem_q[rd_q]) : '0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
